// File: rtl/cv32e40x_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40x_pkg
// Shared types and helpers for the iterative divider sequencer.
//   div_opcode_e   : DIV / DIVU / REM / REMU operation encoding
//   div_state_e    : divider sequencer states
//   DIV_FIXED_ITER : starting bit index when latency must not depend on data
//   bitrev32       : bit reversal used to feed |divisor| into the ALU CLZ
//   neg_if         : conditional two's complement negation
// ----------------------------------------------------------------------------
package cv32e40x_pkg;

   typedef enum logic [1:0] {
      DIV_DIV  = 2'b00,
      DIV_DIVU = 2'b01,
      DIV_REM  = 2'b10,
      DIV_REMU = 2'b11
   } div_opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CLZ  = 2'b01,
      ITER = 2'b10,
      DONE = 2'b11
   } div_state_e;

   localparam logic [4:0] DIV_FIXED_ITER = 5'd31;

   function automatic logic [31:0] bitrev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = d[31-i];
      end
      return r;
   endfunction

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/cv32e40x_div_seq.sv
// ----------------------------------------------------------------------------
// cv32e40x_div_seq
// Sequencer for the 32-bit DIV/DIVU/REM/REMU instructions in EX. Restoring
// shift-subtract, one quotient bit per cycle, starting from the bit index
// given by the leading-zero count of |divisor|. The CLZ and the barrel
// shifter are borrowed from the ALU through its div side interface.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   valid_i / ready_o     operation request / sequencer can accept
//   operator_i            DIV/DIVU/REM/REMU
//   op_a_i, op_b_i        dividend, divisor
//   kill_i                abort the operation in flight (highest priority)
//   alu_clz_en_o          ALU CLZ request
//   alu_clz_data_rev_o    bit-reversed |divisor| for the ALU CLZ
//   alu_clz_result_i      leading-zero count of |divisor|
//   alu_shift_en_o        ALU shifter request
//   alu_shift_amt_o       left-shift amount for |divisor|
//   alu_op_b_shifted_i    |divisor| << alu_shift_amt_o
//   result_o / valid_o    quotient or remainder / result valid
//   ready_i               downstream (WB) ready
// ----------------------------------------------------------------------------
module cv32e40x_div_seq
   import cv32e40x_pkg::*;
#(
   parameter bit DATA_IND_TIMING = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   output logic        ready_o,
   input  div_opcode_e operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        alu_clz_en_o,
   output logic [31:0] alu_clz_data_rev_o,
   input  logic [5:0]  alu_clz_result_i,
   output logic        alu_shift_en_o,
   output logic [5:0]  alu_shift_amt_o,
   input  logic [31:0] alu_op_b_shifted_i,
   output logic [31:0] result_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam bit FAST_EN = (DATA_IND_TIMING == 1'b0);

   div_state_e  state_r, state_s;
   div_opcode_e op_r;
   logic        sign_a_r, sign_b_r, b_zero_r, ovf_r;
   logic [31:0] rem_r, rem_s, quot_r, quot_s;
   logic [4:0]  cnt_r, cnt_s;
   logic [5:0]  clz_r;
   logic [31:0] result_r, result_s;
   logic        valid_r, clz_en_r, shift_en_r;
   logic [31:0] clz_rev_r;

   logic        in_signed_s, in_rem_s, in_a_neg_s, in_b_neg_s;
   logic        in_b_zero_s, in_ovf_s, accept_s;
   logic [31:0] in_a_abs_s, in_b_abs_s, fast_result_s;
   logic        cnt_ok_s, take_s;
   logic [31:0] rem_step_s, quot_step_s, iter_result_s;

   // Decode of the operands presented this cycle (used only on accept)
   always_comb begin
      in_signed_s = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
      in_rem_s    = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
      in_a_neg_s  = in_signed_s & op_a_i[31];
      in_b_neg_s  = in_signed_s & op_b_i[31];
      in_a_abs_s  = neg_if(op_a_i, in_a_neg_s);
      in_b_abs_s  = neg_if(op_b_i, in_b_neg_s);
      in_b_zero_s = (op_b_i == 32'd0);
      in_ovf_s    = in_signed_s & (op_a_i == 32'h8000_0000) & (op_b_i == 32'hFFFF_FFFF);
      if (in_b_zero_s) begin
         fast_result_s = in_rem_s ? op_a_i : 32'hFFFF_FFFF;
      end else begin
         fast_result_s = in_rem_s ? 32'd0 : 32'h8000_0000;
      end
   end

   assign ready_o  = (state_r == IDLE) || ((state_r == DONE) && ready_i);
   assign accept_s = valid_i & ready_o & ~kill_i;

   // One restoring step; with fixed timing the bit indices above clz(|b|)
   // would overflow the 32-bit shifted divisor, so those steps never subtract.
   always_comb begin
      cnt_ok_s    = ({1'b0, cnt_r} <= clz_r);
      take_s      = cnt_ok_s && ({1'b0, rem_r} >= {1'b0, alu_op_b_shifted_i});
      rem_step_s  = take_s ? (rem_r - alu_op_b_shifted_i) : rem_r;
      quot_step_s = take_s ? (quot_r | (32'd1 << cnt_r)) : quot_r;
   end

   // Sign fixup and special-case override for the result leaving ITER
   always_comb begin
      iter_result_s = 32'd0;
      case (op_r)
         DIV_DIV: begin
            if (ovf_r) begin
               iter_result_s = 32'h8000_0000;
            end else if (b_zero_r) begin
               iter_result_s = 32'hFFFF_FFFF;
            end else begin
               iter_result_s = neg_if(quot_step_s, sign_a_r ^ sign_b_r);
            end
         end
         DIV_DIVU: iter_result_s = b_zero_r ? 32'hFFFF_FFFF : quot_step_s;
         DIV_REM:  iter_result_s = ovf_r ? 32'd0 : neg_if(rem_step_s, sign_a_r);
         DIV_REMU: iter_result_s = rem_step_s;
         default:  iter_result_s = 32'd0;
      endcase
   end

   // Next-state and datapath update; kill beats accept, accept beats the FSM
   always_comb begin
      state_s  = state_r;
      rem_s    = rem_r;
      quot_s   = quot_r;
      cnt_s    = cnt_r;
      result_s = result_r;
      if (kill_i) begin
         state_s = IDLE;
      end else if (accept_s) begin
         rem_s  = in_a_abs_s;
         quot_s = 32'd0;
         if (FAST_EN && (in_b_zero_s || in_ovf_s)) begin
            state_s  = DONE;
            result_s = fast_result_s;
         end else begin
            state_s = CLZ;
         end
      end else begin
         case (state_r)
            IDLE: state_s = IDLE;
            CLZ: begin
               cnt_s   = FAST_EN ? alu_clz_result_i[4:0] : DIV_FIXED_ITER;
               state_s = ITER;
            end
            ITER: begin
               rem_s  = rem_step_s;
               quot_s = quot_step_s;
               if (cnt_r == 5'd0) begin
                  state_s  = DONE;
                  result_s = iter_result_s;
               end else begin
                  cnt_s = cnt_r - 5'd1;
               end
            end
            DONE:    state_s = ready_i ? IDLE : DONE;
            default: state_s = IDLE;
         endcase
      end
   end

   // State, datapath and registered output updates
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         op_r       <= DIV_DIV;
         sign_a_r   <= 1'b0;
         sign_b_r   <= 1'b0;
         b_zero_r   <= 1'b0;
         ovf_r      <= 1'b0;
         rem_r      <= 32'd0;
         quot_r     <= 32'd0;
         cnt_r      <= 5'd0;
         clz_r      <= 6'd0;
         result_r   <= 32'd0;
         valid_r    <= 1'b0;
         clz_en_r   <= 1'b0;
         shift_en_r <= 1'b0;
         clz_rev_r  <= 32'd0;
      end else begin
         state_r    <= state_s;
         rem_r      <= rem_s;
         quot_r     <= quot_s;
         cnt_r      <= cnt_s;
         result_r   <= result_s;
         valid_r    <= (state_s == DONE);
         clz_en_r   <= (state_s == CLZ);
         shift_en_r <= (state_s == ITER);
         if (accept_s) begin
            op_r     <= operator_i;
            sign_a_r <= in_a_neg_s;
            sign_b_r <= in_b_neg_s;
            b_zero_r <= in_b_zero_s;
            ovf_r    <= in_ovf_s;
            // Only reload when the CLZ request really starts, so the data
            // lines stay quiet for fast-path operations
            if (state_s == CLZ) begin
               clz_rev_r <= bitrev32(in_b_abs_s);
            end
         end
         if (state_r == CLZ) begin
            clz_r <= alu_clz_result_i;
         end
      end
   end

   assign alu_clz_en_o       = clz_en_r;
   assign alu_clz_data_rev_o = clz_rev_r;
   assign alu_shift_en_o     = shift_en_r;
   assign alu_shift_amt_o    = {1'b0, cnt_r};
   assign result_o           = result_r;
   assign valid_o            = valid_r;

endmodule
